cpu64_mem_arbiter: RTL

Shares a single external memory bus port between the fetch (I-side, read-only) and memory-stage (D-side, read/write) requesters of the 5-stage CPU64 pipeline. It runs one outstanding bus transaction at a time and prioritises the D-side, with a starvation bound for the I-side. It generates the imem/dmem stall signals consumed by the pipeline controller. I-side flushes cause an in-flight fetch response to be discarded.

---
 rtl/cpu64_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu64_mem_arbiter.sv
// Shares one external memory bus port between the CPU64 fetch (I) and
// memory-stage (D) requesters. One bus transaction is in flight at a time.
// D-side wins ties, except that I wins once it has lost STARVE_MAX
// consecutive arbitrations. Flushing the I-side discards its in-flight response.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction in flight; arbitrate among pending requests
// REQ   | bus_req_o high with latched payload, waiting for bus_gnt_i
// RESP  | request accepted, waiting for bus_rvalid_i to finish the access
module cpu64_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  imem_req_i,
    input  logic [ADDR_W-1:0]     imem_addr_i,
    input  logic                  imem_flush_i,
    output logic                  imem_rvalid_o,
    output logic [DATA_W-1:0]     imem_rdata_o,
    output logic                  imem_err_o,
    output logic                  imem_stall_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_W/8-1:0]   dmem_be_i,
    input  logic [ADDR_W-1:0]     dmem_addr_i,
    input  logic [DATA_W-1:0]     dmem_wdata_i,
    output logic                  dmem_rvalid_o,
    output logic [DATA_W-1:0]     dmem_rdata_o,
    output logic                  dmem_err_o,
    output logic                  dmem_stall_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_be_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_err_i
);

    localparam int          BE_W       = DATA_W / 8;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic                drop_q;
    logic [3:0]          starve_q;
    logic [3:0]          starve_d;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                i_pend;
    logic                d_pend;
    logic                grant_i;
    logic                resp_fire;

    // Arbitration decision and starvation counter update for the IDLE cycle.
    always_comb begin
        i_pend   = imem_req_i & ~imem_flush_i;
        d_pend   = dmem_req_i;
        grant_i  = i_pend & (~d_pend | (starve_q == STARVE_LIM));
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (i_pend && d_pend && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Transaction FSM: grant, latch payload, track owner and flush-drop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_I;
            drop_q   <= 1'b0;
            starve_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_pend || d_pend) begin
                        state_q  <= S_REQ;
                        drop_q   <= 1'b0;
                        starve_q <= starve_d;
                        if (grant_i) begin
                            owner_q <= OWN_I;
                            we_q    <= 1'b0;
                            be_q    <= '1;
                            addr_q  <= imem_addr_i;
                            wdata_q <= '0;
                        end else begin
                            owner_q <= OWN_D;
                            we_q    <= dmem_we_i;
                            be_q    <= dmem_be_i;
                            addr_q  <= dmem_addr_i;
                            wdata_q <= dmem_wdata_i;
                        end
                    end
                end
                S_REQ: begin
                    // The request stays up until granted even when flushed.
                    if (owner_q == OWN_I && imem_flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_gnt_i) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus_rvalid_i) begin
                        state_q <= S_IDLE;
                        drop_q  <= 1'b0;
                    end else if (owner_q == OWN_I && imem_flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Response forwarding, stalls and bus drive; everything is held at 0 in reset.
    always_comb begin
        resp_fire     = rst_ni & (state_q == S_RESP) & bus_rvalid_i;
        // A flush arriving together with the response drops it as well.
        imem_rvalid_o = resp_fire & (owner_q == OWN_I) & ~drop_q & ~imem_flush_i;
        dmem_rvalid_o = resp_fire & (owner_q == OWN_D);
        imem_rdata_o  = imem_rvalid_o ? bus_rdata_i : '0;
        imem_err_o    = imem_rvalid_o & bus_err_i;
        dmem_rdata_o  = dmem_rvalid_o ? bus_rdata_i : '0;
        dmem_err_o    = dmem_rvalid_o & bus_err_i;
        imem_stall_o  = rst_ni & imem_req_i & ~imem_flush_i & ~imem_rvalid_o;
        dmem_stall_o  = rst_ni & dmem_req_i & ~dmem_rvalid_o;
        bus_req_o     = rst_ni & (state_q == S_REQ);
        bus_we_o      = rst_ni & we_q;
        bus_be_o      = rst_ni ? be_q : '0;
        bus_addr_o    = rst_ni ? addr_q : '0;
        bus_wdata_o   = rst_ni ? wdata_q : '0;
    end

endmodule
